tmec_chien_search: RTL and testbench

TMEC_CHIEN_SEARCH -- requirements
Module: tmec_chien_search

---
 rtl/tmec_chien_search_pkg.sv | 58 +++++
 rtl/tmec_chien_search_const_mult.sv | 27 ++
 rtl/tmec_chien_search.sv | 137 +++++++++++++
 tb/tb_tmec_chien_search.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmec_chien_search_pkg.sv
// Shared GF(2^M) helpers for the BCH decoder blocks: primitive polynomials,
// field multiply and alpha-power tables, all usable at elaboration time.
package tmec_chien_search_pkg;

    localparam int GF_MAXW = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEARCH
    } chien_state_t;

    function automatic logic [GF_MAXW:0] gf_prim_poly(input int m);
        case (m)
            3:       return 17'h0000B;
            4:       return 17'h00013;
            5:       return 17'h00025;
            6:       return 17'h00043;
            7:       return 17'h00089;
            8:       return 17'h0011D;
            9:       return 17'h00211;
            10:      return 17'h00409;
            11:      return 17'h00805;
            12:      return 17'h01053;
            13:      return 17'h0201B;
            14:      return 17'h04443;
            default: return 17'h08003;
        endcase
    endfunction

    // Shift-and-add multiply with on-the-fly reduction by the field polynomial.
    function automatic logic [GF_MAXW-1:0] gf_mul(input logic [GF_MAXW-1:0] a,
                                                  input logic [GF_MAXW-1:0] b,
                                                  input int m);
        logic [GF_MAXW:0] acc;
        logic [GF_MAXW:0] aa;
        logic [GF_MAXW:0] poly;
        acc  = '0;
        aa   = {1'b0, a};
        poly = gf_prim_poly(m);
        for (int i = 0; i < GF_MAXW; i++) begin
            if (i < m && b[i]) acc = acc ^ aa;
            aa = aa << 1;
            if (aa[m]) aa = aa ^ poly;
        end
        return acc[GF_MAXW-1:0];
    endfunction

    function automatic logic [GF_MAXW-1:0] gf_alpha_pow(input int e, input int m);
        logic [GF_MAXW-1:0] r;
        int ee;
        r  = 1;
        ee = e % ((1 << m) - 1);
        for (int i = 0; i < ee; i++) r = gf_mul(r, 2, m);
        return r;
    endfunction

endpackage

// File: rtl/tmec_chien_search_const_mult.sv
// Combinational GF(2^M) multiply by the fixed constant alpha^POWER, built as
// an XOR of precomputed columns alpha^(POWER+i).
module chien_const_multiplier
    import tmec_chien_search_pkg::*;
#(
    parameter int M     = 4,
    parameter int POWER = 1
) (
    input  logic [M-1:0] din,
    output logic [M-1:0] dout
);

    logic [M-1:0] cols [M];

    for (genvar i = 0; i < M; i++) begin : g_col
        localparam logic [M-1:0] COL = M'(gf_alpha_pow(POWER + i, M));
        assign cols[i] = COL;
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < M; i++) begin
            if (din[i]) dout = dout ^ cols[i];
        end
    end

endmodule

// File: rtl/tmec_chien_search.sv
// Chien search: evaluates the error locator at one codeword position per cycle,
// highest-degree bit first, and flags roots, root count and decode failure.
module tmec_chien_search
    import tmec_chien_search_pkg::*;
#(
    parameter int M = 4,
    parameter int T = 3,
    parameter int N = (1 << M) - 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ch_start,
    input  logic [M*(T+1)-1:0]     sigma,
    output logic                   err_valid,
    output logic                   err,
    output logic                   err_first,
    output logic                   err_last,
    output logic                   busy,
    output logic [$clog2(T+1):0]   err_count,
    output logic                   fail
);

    localparam int S  = (1 << M) - 1 - N;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(T + 1) + 1;
    localparam logic [PW-1:0] POS_LAST = PW'(N - 1);
    localparam logic [PW-1:0] POS_PEN  = PW'((N >= 2) ? N - 2 : 0);
    localparam logic [CW-1:0] CNT_MAX  = CW'(T + 1);

    chien_state_t state_q, state_d;

    logic [M-1:0]  term_p0   [T+1];
    logic [M-1:0]  term_load [T+1];
    logic [M-1:0]  term_step [T+1];
    logic [M-1:0]  sum_p0;
    logic          zero_p0;
    logic          err_p1;
    logic [PW-1:0] pos_p1;
    logic [CW-1:0] count_q;
    logic [CW-1:0] deg_q, deg_d;
    logic          sig0_zero_q;
    logic          done_q;
    logic          compute_en;
    logic          last_calc;

    for (genvar j = 0; j <= T; j++) begin : g_term
        localparam logic [GF_MAXW-1:0] LOAD_C = gf_alpha_pow(j * (1 + S), M);
        assign term_load[j] = M'(gf_mul(GF_MAXW'(sigma[j*M +: M]), LOAD_C, M));
        if (j == 0) begin : g_id
            assign term_step[j] = term_p0[j];
        end else begin : g_mul
            chien_const_multiplier #(.M(M), .POWER(j)) u_mul (
                .din  (term_p0[j]),
                .dout (term_step[j])
            );
        end
    end

    always_comb begin
        deg_d = '0;
        for (int j = 1; j <= T; j++) begin
            if (sigma[j*M +: M] != '0) deg_d = CW'(j);
        end
    end

    // Stage p0: XOR-sum of the term registers and zero detect
    always_comb begin
        sum_p0 = '0;
        for (int j = 0; j <= T; j++) sum_p0 = sum_p0 ^ term_p0[j];
    end
    assign zero_p0 = (sum_p0 == '0);

    // The last SEARCH cycle only displays; its terms are already past the end.
    assign compute_en = (state_q == ST_LOAD) ||
                        (state_q == ST_SEARCH && pos_p1 != POS_LAST);
    assign last_calc  = (state_q == ST_LOAD && N == 1) ||
                        (state_q == ST_SEARCH && N >= 2 && pos_p1 == POS_PEN);

    always_comb begin
        state_d = state_q;
        if (ch_start) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD:   state_d = ST_SEARCH;
                ST_SEARCH: if (pos_p1 == POS_LAST) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Stage p1: registered root flag, position and result bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            err_p1      <= 1'b0;
            pos_p1      <= '0;
            count_q     <= '0;
            deg_q       <= '0;
            sig0_zero_q <= 1'b0;
            done_q      <= 1'b0;
            for (int j = 0; j <= T; j++) term_p0[j] <= '0;
        end else begin
            state_q <= state_d;
            if (ch_start) begin
                for (int j = 0; j <= T; j++) term_p0[j] <= term_load[j];
                err_p1      <= 1'b0;
                pos_p1      <= '0;
                count_q     <= '0;
                done_q      <= 1'b0;
                deg_q       <= deg_d;
                sig0_zero_q <= (sigma[M-1:0] == '0);
            end else begin
                if (state_q != ST_IDLE) begin
                    for (int j = 0; j <= T; j++) term_p0[j] <= term_step[j];
                end
                err_p1 <= compute_en & zero_p0;
                if (compute_en && zero_p0 && count_q != CNT_MAX) count_q <= count_q + 1'b1;
                if (last_calc) done_q <= 1'b1;
                if (state_q == ST_SEARCH) begin
                    if (pos_p1 != POS_LAST) pos_p1 <= pos_p1 + 1'b1;
                end else begin
                    pos_p1 <= '0;
                end
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign err_valid = (state_q == ST_SEARCH);
    assign err       = err_valid & err_p1;
    assign err_first = err_valid && (pos_p1 == '0);
    assign err_last  = err_valid && (pos_p1 == POS_LAST);
    assign err_count = count_q;
    assign fail      = done_q && ((count_q != deg_q) || sig0_zero_q);

endmodule

// File: tb/tb_tmec_chien_search.sv
// Scoreboard bench: a full-length (N=15) and a shortened (N=10) search unit
// checked against a log/antilog-table model of the locator evaluation.
module tb_tmec_chien_search;

    localparam int M  = 4;
    localparam int T  = 3;
    localparam int SW = M * (T + 1);

    typedef struct {
        logic       err;
        logic       first;
        logic       last;
        logic [2:0] cnt;
        logic       fail;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          st [2];
    logic [SW-1:0] sg [2];
    logic          ev [2];
    logic          er [2];
    logic          ef [2];
    logic          el [2];
    logic          bz [2];
    logic [2:0]    cnt [2];
    logic          fl [2];

    int   errors = 0;
    int   checks = 0;
    int   vcnt [2];
    int   exp_cnt [2];
    int   exp_fail [2];
    int   alog [15];
    int   lg [16];
    exp_t q0 [$];
    exp_t q1 [$];

    tmec_chien_search #(.M(M), .T(T), .N(15)) u_full (
        .clk(clk), .reset(reset), .ch_start(st[0]), .sigma(sg[0]),
        .err_valid(ev[0]), .err(er[0]), .err_first(ef[0]), .err_last(el[0]),
        .busy(bz[0]), .err_count(cnt[0]), .fail(fl[0])
    );

    tmec_chien_search #(.M(M), .T(T), .N(10)) u_short (
        .clk(clk), .reset(reset), .ch_start(st[1]), .sigma(sg[1]),
        .err_valid(ev[1]), .err(er[1]), .err_first(ef[1]), .err_last(el[1]),
        .busy(bz[1]), .err_count(cnt[1]), .fail(fl[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int n_of(input int i);
        return (i == 0) ? 15 : 10;
    endfunction

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return alog[(lg[a] + lg[b]) % 15];
    endfunction

    function automatic int eval_at(input logic [SW-1:0] s, input int e);
        int acc = 0;
        for (int j = 0; j <= T; j++) begin
            acc = acc ^ gmul(int'((s >> (M * j)) & 16'hF), alog[(j * e) % 15]);
        end
        return acc;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t pop_exp(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Expected per-position records for one burst; upto < n models an abort.
    task automatic push_burst(input int i, input logic [SW-1:0] s, input int upto);
        int n = n_of(i);
        int sh = 15 - n;
        int c = 0;
        int deg = 0;
        exp_t e;
        logic roots [15];
        for (int p = 0; p < n; p++) begin
            roots[p] = (eval_at(s, p + 1 + sh) == 0);
            if (roots[p] && c < T + 1) c++;
        end
        for (int j = 1; j <= T; j++) if (((s >> (M * j)) & 16'hF) != 0) deg = j;
        exp_cnt[i]  = c;
        exp_fail[i] = (c != deg) || ((s & 16'hF) == 0);
        for (int p = 0; p < upto; p++) begin
            e.err   = roots[p];
            e.first = (p == 0);
            e.last  = (p == n - 1);
            e.cnt   = 3'(c);
            e.fail  = 1'(exp_fail[i]);
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (ev[i] === 1'b1) begin
                vcnt[i]++;
                if (qsize(i) == 0) begin
                    chk($sformatf("u%0d_unexpected_valid", i), 1, 0);
                end else begin
                    e = pop_exp(i);
                    chk($sformatf("u%0d_err", i), er[i], e.err);
                    chk($sformatf("u%0d_first", i), ef[i], e.first);
                    chk($sformatf("u%0d_last", i), el[i], e.last);
                    if (e.last) begin
                        chk($sformatf("u%0d_count", i), cnt[i], e.cnt);
                        chk($sformatf("u%0d_fail", i), fl[i], e.fail);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int i, input logic [SW-1:0] s);
        sg[i] = s;
        st[i] = 1'b1;
        step();
        st[i] = 1'b0;
    endtask

    task automatic check_all_zero(input int i, input string tag);
        chk({tag, "_valid"}, ev[i], 0);
        chk({tag, "_err"}, er[i], 0);
        chk({tag, "_first"}, ef[i], 0);
        chk({tag, "_last"}, el[i], 0);
        chk({tag, "_busy"}, bz[i], 0);
        chk({tag, "_count"}, cnt[i], 0);
        chk({tag, "_fail"}, fl[i], 0);
    endtask

    task automatic wait_idle(input int i, input int budget);
        int k = 0;
        while (bz[i] === 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk($sformatf("u%0d_idle_timeout", i), bz[i], 0);
    endtask

    task automatic run_full(input int i, input logic [SW-1:0] s, input string tag);
        vcnt[i] = 0;
        push_burst(i, s, n_of(i));
        pulse(i, s);
        chk({tag, "_load_valid"}, ev[i], 0);
        chk({tag, "_load_busy"}, bz[i], 1);
        step();
        chk({tag, "_lat2_valid"}, ev[i], 1);
        wait_idle(i, n_of(i) + 10);
        chk({tag, "_burst_len"}, vcnt[i], n_of(i));
        chk({tag, "_drain"}, qsize(i), 0);
        repeat (2) step();
        chk({tag, "_hold_count"}, cnt[i], exp_cnt[i]);
        chk({tag, "_hold_fail"}, fl[i], exp_fail[i]);
    endtask

    initial begin
        int v = 1;
        for (int k = 0; k < 15; k++) begin
            alog[k] = v;
            lg[v]   = k;
            v = v << 1;
            if ((v & 16) != 0) v = v ^ 19;
        end
        vcnt[0] = 0;
        vcnt[1] = 0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0;
            sg[i] = '0;
        end
        repeat (3) step();
        check_all_zero(0, "reset_u0");
        check_all_zero(1, "reset_u1");
        reset = 1'b0;
        step();

        // Full-length code: no errors, single root, double root.
        run_full(0, 16'h0001, "none");
        run_full(0, 16'h0081, "one_root");
        run_full(0, 16'h0EE1, "two_roots");

        // Shortened code: root at the final position, then degree 2 with
        // roots only in the shortened-away range.
        run_full(1, 16'h0011, "short_root");
        run_full(1, 16'h0168, "short_noroot");

        for (int r = 0; r < 3; r++) run_full(0, SW'($urandom), $sformatf("rand%0d", r));

        // Restart at p=6: first burst ends without err_last.
        vcnt[0] = 0;
        push_burst(0, 16'h0EE1, 7);
        pulse(0, 16'h0EE1);
        repeat (7) step();
        push_burst(0, 16'h0081, 15);
        pulse(0, 16'h0081);
        chk("abort_gap_valid", ev[0], 0);
        chk("abort_gap_last", el[0], 0);
        step();
        chk("abort_restart_valid", ev[0], 1);
        chk("abort_restart_first", ef[0], 1);
        wait_idle(0, 30);
        chk("abort_burst_len", vcnt[0], 22);
        chk("abort_drain", qsize(0), 0);

        // Reset at p=3 ends the burst on the next cycle.
        vcnt[0] = 0;
        push_burst(0, 16'h0EE1, 4);
        pulse(0, 16'h0EE1);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero(0, "midreset");
        chk("midreset_burst_len", vcnt[0], 4);
        chk("midreset_drain", qsize(0), 0);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        sg[0] = 16'h0001;
        st[0] = 1'b1;
        step();
        reset = 1'b0;
        st[0] = 1'b0;
        chk("rst_prio_busy", bz[0], 0);
        step();
        chk("rst_prio_busy2", bz[0], 0);
        chk("rst_prio_valid", ev[0], 0);

        // All-zero locator: every position flagged, count saturates, fail.
        run_full(0, 16'h0000, "zero_sigma");
        chk("zero_sigma_count_sat", cnt[0], 4);
        chk("zero_sigma_fail", fl[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
